// File: rtl/loopback_pkg.sv
// Shared types for the loopback checker and its sequencing controller:
// the checker mode encoding and the controller state machine.
package loopback_pkg;

    typedef enum logic [1:0] {
        MODE_RESET = 2'b00,
        MODE_ALIGN = 2'b01,
        MODE_TEST  = 2'b10
    } loopback_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_ALIGN = 3'd2,
        ST_TEST  = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

    // IDLE, RST and DONE all hold the checker in reset.
    function automatic loopback_mode_t state_to_mode(input ctrl_state_t s);
        case (s)
            ST_ALIGN: return MODE_ALIGN;
            ST_TEST:  return MODE_TEST;
            default:  return MODE_RESET;
        endcase
    endfunction

endpackage

// File: rtl/loopback_ctrl_lock_detect.sv
// Alignment lock detector: declares lock once the checker latency has held
// the same value for lock_cycles consecutive cycles.
module lock_detect #(
    parameter int n_addr = 8,
    parameter int n_tmr  = 32
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              clear,
    input  logic [n_addr-1:0] latency,
    input  logic [n_tmr-1:0]  lock_cycles,
    output logic              locked
);

    logic [n_addr-1:0] r_prev;
    logic              r_prev_vld;
    logic [n_tmr-1:0]  r_count;

    logic              w_match;
    logic [n_tmr-1:0]  w_count_next;
    logic [n_tmr-1:0]  w_lock_eff;

    // r_prev_vld is low on the first ALIGN cycle, so that cycle never matches.
    assign w_match      = r_prev_vld && (latency == r_prev);
    assign w_count_next = !w_match   ? '0 :
                          (&r_count) ? r_count : r_count + 1'b1;
    assign w_lock_eff   = (lock_cycles == '0) ? n_tmr'(1) : lock_cycles;
    assign locked       = !clear && (w_count_next >= w_lock_eff);

    always_ff @(posedge clk) begin
        if (!rstb || clear) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_count    <= '0;
        end else begin
            r_prev     <= latency;
            r_prev_vld <= 1'b1;
            r_count    <= w_count_next;
        end
    end

endmodule

// File: rtl/loopback_ctrl.sv
// Sequencing controller for the bit-error loopback checker: RESET -> ALIGN ->
// TEST, lock on stable latency, then latch error count and pass/fail verdict.
module loopback_ctrl
    import loopback_pkg::*;
#(
    parameter int n_addr       = 8,
    parameter int n_tmr        = 32,
    parameter int reset_cycles = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              abort,
    input  logic [63:0]       test_bits,
    input  logic [63:0]       max_err,
    input  logic [n_tmr-1:0]  lock_cycles,
    input  logic [n_tmr-1:0]  align_timeout,
    input  logic [63:0]       correct_bits,
    input  logic [63:0]       total_bits,
    input  logic [n_addr-1:0] latency,
    output logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [63:0]       err_bits,
    output logic [n_addr-1:0] lat_lock
);

    localparam int RST_W = $clog2(reset_cycles);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(reset_cycles - 1);

    ctrl_state_t       r_state;
    logic [RST_W-1:0]  r_rst_cnt;
    logic [n_tmr-1:0]  r_tmr;
    logic              r_pass;
    logic              r_timeout;
    logic [63:0]       r_err_bits;
    logic [n_addr-1:0] r_lat_lock;

    logic              w_locked;
    logic [n_tmr-1:0]  w_tmr_inc;
    logic [63:0]       w_test_eff;
    logic [63:0]       w_err;

    lock_detect #(
        .n_addr (n_addr),
        .n_tmr  (n_tmr)
    ) u_lock_detect (
        .clk         (clk),
        .rstb        (rstb),
        .clear       (r_state != ST_ALIGN),
        .latency     (latency),
        .lock_cycles (lock_cycles),
        .locked      (w_locked)
    );

    assign w_tmr_inc  = (&r_tmr) ? r_tmr : r_tmr + 1'b1;
    assign w_test_eff = (test_bits == 64'd0) ? 64'd1 : test_bits;
    assign w_err      = total_bits - correct_bits;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state    <= ST_IDLE;
            r_rst_cnt  <= '0;
            r_tmr      <= '0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_err_bits <= '0;
            r_lat_lock <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_RST;
                        r_rst_cnt  <= '0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_err_bits <= '0;
                        r_lat_lock <= '0;
                    end
                end
                ST_RST: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state <= ST_ALIGN;
                        r_tmr   <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_ALIGN: begin
                    // Lock is checked first so it wins over a same-cycle timeout.
                    if (w_locked) begin
                        r_lat_lock <= latency;
                        r_state    <= ST_TEST;
                    end else if ((align_timeout != '0) && (w_tmr_inc >= align_timeout)) begin
                        r_timeout  <= 1'b1;
                        r_pass     <= 1'b0;
                        r_err_bits <= '0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_tmr <= w_tmr_inc;
                    end
                end
                ST_TEST: begin
                    if (total_bits >= w_test_eff) begin
                        r_err_bits <= w_err;
                        r_pass     <= (w_err <= max_err);
                        r_state    <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mode     = state_to_mode(r_state);
    assign busy     = (r_state == ST_RST) || (r_state == ST_ALIGN) || (r_state == ST_TEST);
    assign done     = (r_state == ST_DONE);
    assign pass     = r_pass;
    assign timeout  = r_timeout;
    assign err_bits = r_err_bits;
    assign lat_lock = r_lat_lock;

endmodule

// File: tb/tb_loopback_ctrl.sv
// Bench for loopback_ctrl: a small checker model closes the loop, a vector
// table drives full runs, and short sequences cover abort, reset and timeout.
module tb_loopback_ctrl;

    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] test_bits = '0;
    logic [63:0] max_err = '0;
    logic [31:0] lock_cycles = '0;
    logic [31:0] align_timeout = '0;
    logic [63:0] correct_bits = '0;
    logic [63:0] total_bits = '0;
    logic [7:0]  latency = 8'd5;
    logic [1:0]  mode;
    logic        busy, done, pass, timeout;
    logic [63:0] err_bits;
    logic [7:0]  lat_lock;

    logic        scramble = 1'b0;
    int          n_inject = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    loopback_ctrl #(
        .n_addr       (8),
        .n_tmr        (32),
        .reset_cycles (RC)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .start         (start),
        .abort         (abort),
        .test_bits     (test_bits),
        .max_err       (max_err),
        .lock_cycles   (lock_cycles),
        .align_timeout (align_timeout),
        .correct_bits  (correct_bits),
        .total_bits    (total_bits),
        .latency       (latency),
        .mode          (mode),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_bits      (err_bits),
        .lat_lock      (lat_lock)
    );

    // Checker model: counters follow mode one cycle late; the first n_inject bits are errored.
    always @(posedge clk) begin
        if (scramble) latency <= latency + 8'd1;
        else          latency <= 8'd5;
        if (mode == 2'b00) begin
            total_bits   <= '0;
            correct_bits <= '0;
        end else if (mode == 2'b10) begin
            total_bits <= total_bits + 64'd1;
            if (total_bits >= 64'(n_inject)) correct_bits <= correct_bits + 64'd1;
        end
    end

    typedef struct {
        logic [63:0] tbits;
        logic [63:0] merr;
        logic [31:0] lc;
        logic [31:0] to;
        int          ninj;
        bit          scr;
        bit          e_to;
        bit          e_pass;
        logic [63:0] e_err;
        logic [7:0]  e_lat;
        int          e_align;
        int          e_test;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   align_c;
        int   test_c;
        int   cyc;
        v = vecs[i];
        align_c = 0;
        test_c = 0;
        cyc = 0;
        @(negedge clk);
        test_bits = v.tbits; max_err = v.merr; lock_cycles = v.lc; align_timeout = v.to;
        n_inject = v.ninj; scramble = v.scr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 5000) begin
            if (mode == 2'b01) align_c++;
            if (mode == 2'b10) test_c++;
            if (done) break;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d_done", i), 64'(done), 64'd1);
        chk($sformatf("v%0d_timeout", i), 64'(timeout), 64'(v.e_to));
        chk($sformatf("v%0d_pass", i), 64'(pass), 64'(v.e_pass));
        chk($sformatf("v%0d_err_bits", i), err_bits, v.e_err);
        chk($sformatf("v%0d_lat_lock", i), 64'(lat_lock), 64'(v.e_lat));
        chk($sformatf("v%0d_align_cycles", i), 64'(align_c), 64'(v.e_align));
        chk($sformatf("v%0d_test_cycles", i), 64'(test_c), 64'(v.e_test));
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_done_hold", i), 64'(done), 64'd1);
        chk($sformatf("v%0d_mode_done", i), 64'(mode), 64'd0);
        chk($sformatf("v%0d_err_hold", i), err_bits, v.e_err);
        $display("vec %0d: err_bits=%0d pass=%0b timeout=%0b lat_lock=%0d align=%0d test=%0d",
                 i, err_bits, pass, timeout, lat_lock, align_c, test_c);
    endtask

    task automatic wait_mode(input logic [1:0] m, input string name);
        int cyc;
        cyc = 0;
        while (mode != m && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, 64'(mode), 64'(m));
    endtask

    initial begin
        //          tbits  merr lc  to   ninj scr e_to e_pass e_err e_lat e_align e_test
        vecs[0] = '{64'd1000, 64'd0, 32'd8, 32'd0,   0, 1'b0, 1'b0, 1'b1, 64'd0, 8'd5, 9,   1001};
        vecs[1] = '{64'd1000, 64'd2, 32'd8, 32'd0,   3, 1'b0, 1'b0, 1'b0, 64'd3, 8'd5, 9,   1001};
        vecs[2] = '{64'd1000, 64'd3, 32'd8, 32'd0,   3, 1'b0, 1'b0, 1'b1, 64'd3, 8'd5, 9,   1001};
        vecs[3] = '{64'd1000, 64'd0, 32'd8, 32'd200, 0, 1'b1, 1'b1, 1'b0, 64'd0, 8'd0, 200, 0};
        vecs[4] = '{64'd0,    64'd0, 32'd0, 32'd0,   1, 1'b0, 1'b0, 1'b0, 64'd1, 8'd5, 2,   2};
        vecs[5] = '{64'd20,   64'd0, 32'd8, 32'd9,   0, 1'b0, 1'b0, 1'b1, 64'd0, 8'd5, 9,   21};
        vecs[6] = '{64'd20,   64'd0, 32'd8, 32'd8,   0, 1'b0, 1'b1, 1'b0, 64'd0, 8'd0, 8,   0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_mode", 64'(mode), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_err_bits", err_bits, 64'd0);
        chk("rst_lat_lock", 64'(lat_lock), 64'd0);
        rstb = 1'b1;

        // Mode timing, start while busy, abort mid-TEST with start in the same cycle
        @(negedge clk);
        test_bits = 64'd1000; max_err = '0; lock_cycles = 32'd8; align_timeout = '0;
        n_inject = 0; scramble = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_mode_rst", 64'(mode), 64'd0);
        repeat (RC - 1) @(negedge clk);
        chk("rst_hold_mode", 64'(mode), 64'd0);
        @(negedge clk);
        chk("align_entry_mode", 64'(mode), 64'd1);
        wait_mode(2'b10, "reach_test");
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_mode", 64'(mode), 64'd2);
        chk("start_ignored_busy", 64'(busy), 64'd1);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_mode", 64'(mode), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_keep_lat", 64'(lat_lock), 64'd5);
        repeat (3) @(negedge clk);
        chk("abort_idle_stays", 64'(busy), 64'd0);
        $display("seq abort: mode=%0d busy=%0b lat_lock=%0d", mode, busy, lat_lock);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Abort while in DONE: done drops, latched timeout verdict retained
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_in_done", 64'(done), 64'd0);
        chk("abort_in_done_busy", 64'(busy), 64'd0);
        chk("abort_keep_timeout", 64'(timeout), 64'd1);
        $display("seq abort_done: done=%0b timeout=%0b", done, timeout);

        // Timeout disabled: stays in ALIGN, then rstb pulse forces reset values
        @(negedge clk);
        lock_cycles = 32'd8; align_timeout = '0; scramble = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_mode(2'b01, "noto_reach_align");
        repeat (300) @(negedge clk);
        chk("noto_still_align", 64'(mode), 64'd1);
        chk("noto_done", 64'(done), 64'd0);
        chk("noto_timeout", 64'(timeout), 64'd0);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        chk("midrst_mode", 64'(mode), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_pass", 64'(pass), 64'd0);
        chk("midrst_timeout", 64'(timeout), 64'd0);
        chk("midrst_err_bits", err_bits, 64'd0);
        chk("midrst_lat_lock", 64'(lat_lock), 64'd0);
        repeat (2) @(negedge clk);
        chk("midrst_idle_stays", 64'(busy), 64'd0);
        $display("seq midrst: mode=%0d busy=%0b done=%0b", mode, busy, done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loopback_ctrl.md
# loopback_ctrl

Sequencing controller for the bit-error loopback checker. Drives the checker's 2-bit `mode` through RESET → ALIGN → TEST and declares alignment lock when the checker's `latency` output stops moving. It stops the test after a programmed number of checked bits, then latches error count, locked latency and a pass/fail verdict. It sits on the checker's `clk_rx` clock, directly upstream of the checker's `mode` input and downstream of its `correct_bits` / `total_bits` / `latency` outputs.

## Interface
Parameters:
- `n_addr`, 8: checker address width; width of `latency`.
- `n_tmr`, 32: width of the lock and timeout counters.
- `reset_cycles`, 16: cycles `mode` is held at RESET before ALIGN; legal minimum 2.

Ports:
- `clk`  input  1  checker RX clock.
- `rstb`  input  1  synchronous, active-low reset.
- `start`  input  1  begin a run; sampled only in IDLE or DONE.
- `abort`  input  1  return to IDLE from any state.
- `test_bits`  input  64  bits to check in TEST; 0 is treated as 1.
- `max_err`  input  64  maximum error count that still passes.
- `lock_cycles`  input  n_tmr  consecutive stable-latency cycles required for lock; 0 is treated as 1.
- `align_timeout`  input  n_tmr  maximum cycles allowed in ALIGN; 0 disables the timeout.
- `correct_bits`  input  64  from the checker.
- `total_bits`  input  64  from the checker.
- `latency`  input  n_addr  from the checker.
- `mode`  output  2  to the checker: 2'b00 RESET, 2'b01 ALIGN, 2'b10 TEST.
- `busy`  output  1  high in the RST, ALIGN and TEST states.
- `done`  output  1  high in DONE.
- `pass`  output  1  verdict; valid while `done` is high.
- `timeout`  output  1  the ALIGN phase timed out.
- `err_bits`  output  64  latched value of `total_bits - correct_bits`.
- `lat_lock`  output  n_addr  latency value captured at lock.

## Operation
- States: IDLE, RST, ALIGN, TEST, DONE.
- `mode` is decoded from the state register:
  - IDLE, RST, DONE → 2'b00.
  - ALIGN → 2'b01.
  - TEST → 2'b10.
- IDLE/DONE → RST on `start`. Entering RST clears `pass`, `timeout`, `err_bits` and `lat_lock`.
- RST: a cycle counter runs. After exactly `reset_cycles` cycles in RST, go to ALIGN.
- ALIGN lock detection (sub-module):
  - `latency` is registered each cycle.
  - The stability count increments when `latency` equals the registered previous value, and clears to 0 otherwise.
  - The first ALIGN cycle always counts as a mismatch.
  - When the stability count reaches the effective `lock_cycles`: capture `lat_lock` = current `latency` and go to TEST.
- ALIGN timeout: the timeout counter counts cycles spent in ALIGN. If `align_timeout` is nonzero and the counter reaches it before lock, set `timeout` = 1, `pass` = 0, `err_bits` = 0, and go to DONE.
- If lock and timeout occur in the same cycle, lock wins.
- TEST: when `total_bits` ≥ effective `test_bits`, latch `err_bits = total_bits - correct_bits` (64-bit unsigned), set `pass = (err_bits ≤ max_err)`, and go to DONE.
- DONE: hold all results until `start` or `abort`.
- `abort` takes priority over every other event, including `start` and completion in the same cycle:
  - Next state is IDLE.
  - Results already latched are retained.
  - `done` = 0.
- `start` while `busy` is ignored.
- Counters saturate; none wrap.

## Timing
- Reset values: `mode` = 2'b00, `busy` = 0, `done` = 0, `pass` = 0, `timeout` = 0, `err_bits` = 0, `lat_lock` = 0, state = IDLE.
- `rstb` low at any point, mid-run included, forces the reset values at the next edge.
- `start` sampled at edge k → state RST and `busy` = 1 from k+1.
- `mode` = 2'b01 from edge k+1+`reset_cycles`.
- The checker's counters lag `mode` by one cycle. The TEST exit compare therefore sees `total_bits` = `test_bits` exactly, so the latched values are exact.
- Checker counts that continue after the exit are ignored.
- `done`, `pass` and `err_bits` update on the same edge the state enters DONE.
- All outputs are registered or decoded directly from registers, with no combinational path from inputs to outputs.

## Structure
- `loopback_pkg` holds:
  - typedef `loopback_mode_t` (RESET/ALIGN/TEST encodings), shared with the checker;
  - the controller state enum.
- Sub-module `lock_detect`: `latency` history register plus saturating stability counter. Ports: `clk`, `rstb`, `clear`, `latency`, `lock_cycles`; output `locked`.
- The top level holds the FSM, the RST and timeout counters, and the result latches.

## Test plan
- Clean loop (checker with 5-cycle channel delay), `test_bits` = 1000, `lock_cycles` = 8, `max_err` = 0 → `mode` sequence 00/01/10/00, `lat_lock` = 5, `err_bits` = 0, `pass` = 1, `done` held high.
- Inject 3 bit errors in TEST, `max_err` = 2 → `err_bits` = 3, `pass` = 0. Repeat with `max_err` = 3 → `pass` = 1.
- Scrambled RX data (never locks), `align_timeout` = 200 → DONE 200 cycles after ALIGN entry, `timeout` = 1, `pass` = 0. Repeat with `align_timeout` = 0 → remains in ALIGN indefinitely.
- `abort` pulse mid-TEST → IDLE next cycle, `mode` = 00, `done` = 0. A subsequent `start` runs normally. `start` pulses while busy are ignored.
- `rstb` low for one cycle during ALIGN → all outputs at reset values next edge, state IDLE.
- Edge values `test_bits` = 0 and `lock_cycles` = 0 → behave as 1: TEST lasts one counted bit, lock after the first stable cycle.
